float_to_fixed_pipe: RTL

FLOAT_TO_FIXED_PIPE -- requirements
Module: float_to_fixed_pipe

---
 rtl/float_fixed_pkg.sv | 8 +
 rtl/float_to_fixed_shift.sv | 23 ++
 rtl/float_to_fixed_pipe.sv | 123 ++++++++++++
 3 files changed

// File: rtl/float_fixed_pkg.sv
// float_fixed_pkg: shared operand classes, shift-direction encoding and exponent bias
package float_fixed_pkg;
  typedef enum logic [2:0] {ZERO, DENORM, NORMAL, INF, NAN} floatClass_e;
  typedef enum logic {SH_LEFT = 1'b0, SH_RIGHT = 1'b1} shiftDir_e;
  function automatic int expBias(input int expBits);
    return (1 << (expBits - 1)) - 1;
  endfunction
endpackage

// File: rtl/float_to_fixed_shift.sv
// float_to_fixed_shift: barrel shifter of the significand; ovf flags bits lost above FIXEDSIZE
module float_to_fixed_shift
  import float_fixed_pkg::*;
#(
  parameter int SIGBITS = 24,
  parameter int FIXEDSIZE = 32,
  parameter int AMTBITS = 20
) (
  input  logic [SIGBITS-1:0]   sig,
  input  shiftDir_e            dir,
  input  logic [AMTBITS-1:0]   amt,
  output logic [FIXEDSIZE-1:0] mag,
  output logic                 ovf
);
  localparam int EW = FIXEDSIZE + SIGBITS;
  logic [EW-1:0] wide;
  // A left shift of at least FIXEDSIZE pushes any set bit past the window even when wide wraps it out
  always_comb begin
    wide = dir == SH_LEFT ? EW'(sig) << amt : EW'(sig) >> amt;
    mag = wide[FIXEDSIZE-1:0];
    ovf = |wide[EW-1:FIXEDSIZE] | (dir == SH_LEFT & amt >= AMTBITS'(FIXEDSIZE) & |sig);
  end
endmodule

// File: rtl/float_to_fixed_pipe.sv
// float_to_fixed_pipe: 3-stage float to signed fixed converter (classify, shift, sign/clamp).
// Define SATURATE_EN to clamp overflowed results instead of wrapping.
module float_to_fixed_pipe
  import float_fixed_pkg::*;
#(
  parameter int FLOATSIZE = 32,
  parameter int FIXEDSIZE = 32,
  parameter int RADIXPOINTSIZE = 6,
  parameter int EXPONENTBITS = 8,
  parameter int MANTISSABITS = 23
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      InValid,
  output logic                      OutReady,
  input  logic [FLOATSIZE-1:0]      InFloat,
  input  logic [RADIXPOINTSIZE-1:0] InRadixPoint,
  output logic                      OutValid,
  input  logic                      InReady,
  output logic [FIXEDSIZE-1:0]      OutFixed,
  output logic                      OutOverflow,
  output logic                      OutInvalid
);
  localparam int BIAS = expBias(EXPONENTBITS);
  localparam int SHW = EXPONENTBITS + RADIXPOINTSIZE + $clog2(MANTISSABITS + 1) + 2;
  localparam logic [FIXEDSIZE-1:0] MAXPOS = {1'b0, {(FIXEDSIZE - 1){1'b1}}};
  localparam logic [FIXEDSIZE-1:0] MINNEG = {1'b1, {(FIXEDSIZE - 1){1'b0}}};
  logic [EXPONENTBITS-1:0] expField, effExp;
  logic [MANTISSABITS-1:0] mantField;
  logic [SHW-1:0] shiftVal, inAmt;
  floatClass_e inCls;
  shiftDir_e inDir;
  logic s1Valid, s1Sign;
  floatClass_e s1Cls;
  logic [MANTISSABITS:0] s1Sig;
  shiftDir_e s1Dir;
  logic [SHW-1:0] s1Amt;
  logic [FIXEDSIZE-1:0] shMag;
  logic shOvf;
  logic s2Valid, s2Sign, s2Ovf;
  floatClass_e s2Cls;
  logic [FIXEDSIZE-1:0] s2Mag, signedMag, resFixed;
  logic magOvf, resOvf;
  // One global advance: the whole pipe freezes whenever the result register is blocked
  assign OutReady = ~OutValid | InReady;
  always_comb begin
    expField = InFloat[FLOATSIZE-2 -: EXPONENTBITS];
    mantField = InFloat[MANTISSABITS-1:0];
    effExp = expField == '0 ? EXPONENTBITS'(1) : expField;
    shiftVal = SHW'(effExp) + SHW'(InRadixPoint) - SHW'(BIAS + MANTISSABITS);
    inDir = (~shiftVal[SHW-1] & |shiftVal) ? SH_LEFT : SH_RIGHT;
    inAmt = inDir == SH_LEFT ? shiftVal : -shiftVal;
    inCls = expField == '0 ? (mantField == '0 ? ZERO : DENORM) :
            &expField ? (mantField == '0 ? INF : NAN) : NORMAL;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1Valid <= 1'b0;
      s1Sign <= 1'b0;
      s1Cls <= ZERO;
      s1Sig <= '0;
      s1Dir <= SH_RIGHT;
      s1Amt <= '0;
    end else if (OutReady) begin
      s1Valid <= InValid;
      s1Sign <= InFloat[FLOATSIZE-1];
      s1Cls <= inCls;
      s1Sig <= {|expField, mantField};
      s1Dir <= inDir;
      s1Amt <= inAmt;
    end
  end
  float_to_fixed_shift #(
    .SIGBITS(MANTISSABITS + 1),
    .FIXEDSIZE(FIXEDSIZE),
    .AMTBITS(SHW)
  ) u_shift (
    .sig(s1Sig),
    .dir(s1Dir),
    .amt(s1Amt),
    .mag(shMag),
    .ovf(shOvf)
  );
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s2Valid <= 1'b0;
      s2Sign <= 1'b0;
      s2Cls <= ZERO;
      s2Mag <= '0;
      s2Ovf <= 1'b0;
    end else if (OutReady) begin
      s2Valid <= s1Valid;
      s2Sign <= s1Sign;
      s2Cls <= s1Cls;
      s2Mag <= shMag;
      s2Ovf <= shOvf;
    end
  end
  // A magnitude of exactly 2^(FIXEDSIZE-1) is representable only when negative
  always_comb begin
    magOvf = s2Ovf | (s2Mag[FIXEDSIZE-1] & (~s2Sign | |s2Mag[FIXEDSIZE-2:0]));
    resOvf = s2Cls == INF | (s2Cls != NAN & magOvf);
    signedMag = s2Sign ? -s2Mag : s2Mag;
`ifdef SATURATE_EN
    resFixed = s2Cls == NAN ? '0 : resOvf ? (s2Sign ? MINNEG : MAXPOS) : signedMag;
`else
    resFixed = (s2Cls == NAN | s2Cls == INF) ? '0 : signedMag;
`endif
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      OutValid <= 1'b0;
      OutFixed <= '0;
      OutOverflow <= 1'b0;
      OutInvalid <= 1'b0;
    end else if (OutReady) begin
      OutValid <= s2Valid;
      OutFixed <= resFixed;
      OutOverflow <= resOvf;
      OutInvalid <= s2Cls == NAN;
    end
  end
endmodule
